// File: rtl/cdb_arbiter.sv
// Common data bus slave: per-FU result FIFOs drained onto NUM_BCAST broadcast
// lanes by a round-robin scan that starts at rr_ptr.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int PREG_W     = 7,
  parameter int VAL_W      = 32,
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int NUM_BCAST  = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_FU-1:0]                    fu_valid,
  input  logic [NUM_FU*PREG_W-1:0]             fu_preg,
  input  logic [NUM_FU*VAL_W-1:0]              fu_val,
  input  logic [NUM_FU*TAG_W-1:0]              fu_tag,
  output logic                                 cdb_ready,
  output logic [NUM_BCAST-1:0]                 bcast_valid,
  output logic [NUM_BCAST*PREG_W-1:0]          bcast_preg,
  output logic [NUM_BCAST*VAL_W-1:0]           bcast_val,
  output logic [NUM_BCAST*TAG_W-1:0]           bcast_tag,
  output logic [NUM_BCAST*$clog2(NUM_FU)-1:0]  bcast_fu
);

  localparam int FU_W  = $clog2(NUM_FU);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int E_W   = PREG_W + VAL_W + TAG_W;

  logic [E_W-1:0]   mem  [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0] rptr [NUM_FU];
  logic [PTR_W-1:0] wptr [NUM_FU];
  logic [CNT_W-1:0] cnt  [NUM_FU];
  logic [FU_W-1:0]  rr_ptr;
  logic [FU_W-1:0]  last_fu;
  logic [NUM_FU-1:0] not_empty, grant, push, pop;
  logic              any_full;
  logic [NUM_BCAST-1:0] lane_v;
  logic [FU_W-1:0]      lane_fu [NUM_BCAST];

  always_comb begin
    any_full  = 1'b0;
    not_empty = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      not_empty[i] = (cnt[i] != '0);
      if (cnt[i] == CNT_W'(FIFO_DEPTH)) any_full = 1'b1;
    end
  end

  // Ready looks only at registered counts, so a full FIFO blocks even while popping.
  assign cdb_ready = !reset && !flush && !any_full;
  assign push      = fu_valid & {NUM_FU{cdb_ready}};
  assign pop       = grant & {NUM_FU{!flush}};

  always_comb begin
    logic [FU_W:0]   sum;
    logic [FU_W-1:0] idx;
    int              n;
    grant   = '0;
    lane_v  = '0;
    last_fu = rr_ptr;
    sum     = '0;
    idx     = '0;
    n       = 0;
    for (int k = 0; k < NUM_BCAST; k++) lane_fu[k] = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sum = {1'b0, rr_ptr} + (FU_W+1)'(k);
      if (sum >= (FU_W+1)'(NUM_FU)) sum = sum - (FU_W+1)'(NUM_FU);
      idx = sum[FU_W-1:0];
      if (not_empty[idx] && n < NUM_BCAST) begin
        grant[idx]  = 1'b1;
        lane_v[n]   = 1'b1;
        lane_fu[n]  = idx;
        last_fu     = idx;
        n           = n + 1;
      end
    end
  end

  always_comb begin
    logic [E_W-1:0] e;
    e           = '0;
    bcast_preg  = '0;
    bcast_val   = '0;
    bcast_tag   = '0;
    bcast_fu    = '0;
    bcast_valid = (reset || flush) ? '0 : lane_v;
    for (int k = 0; k < NUM_BCAST; k++) begin
      e = mem[lane_fu[k]][rptr[lane_fu[k]]];
      bcast_preg[k*PREG_W +: PREG_W] = e[E_W-1 -: PREG_W];
      bcast_val[k*VAL_W +: VAL_W]    = e[TAG_W +: VAL_W];
      bcast_tag[k*TAG_W +: TAG_W]    = e[TAG_W-1:0];
      bcast_fu[k*FU_W +: FU_W]       = lane_fu[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i])
        mem[i][wptr[i]] <= {fu_preg[i*PREG_W +: PREG_W], fu_val[i*VAL_W +: VAL_W],
                            fu_tag[i*TAG_W +: TAG_W]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        cnt[i]  <= '0;
        rptr[i] <= '0;
        wptr[i] <= '0;
      end
    end else if (flush) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        cnt[i]  <= '0;
        rptr[i] <= '0;
        wptr[i] <= '0;
      end
    end else begin
      if (|grant)
        rr_ptr <= (last_fu == FU_W'(NUM_FU - 1)) ? '0 : last_fu + FU_W'(1);
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PTR_W'(1);
        if (pop[i])  rptr[i] <= rptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter at default parameters (4 FUs, 2 lanes, depth 2).
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [3:0]   fu_valid;
  logic [27:0]  fu_preg;
  logic [127:0] fu_val;
  logic [19:0]  fu_tag;
  logic         cdb_ready;
  logic [1:0]   bcast_valid;
  logic [13:0]  bcast_preg;
  logic [63:0]  bcast_val;
  logic [9:0]   bcast_tag;
  logic [3:0]   bcast_fu;

  int n_cmp = 0;
  int n_mis = 0;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_preg(fu_preg), .fu_val(fu_val), .fu_tag(fu_tag),
    .cdb_ready(cdb_ready), .bcast_valid(bcast_valid), .bcast_preg(bcast_preg),
    .bcast_val(bcast_val), .bcast_tag(bcast_tag), .bcast_fu(bcast_fu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fu();
    fu_valid = '0;
    fu_preg  = '0;
    fu_val   = '0;
    fu_tag   = '0;
  endtask

  task automatic set_fu(input int i, input logic [6:0] p, input logic [31:0] v, input logic [4:0] t);
    fu_valid[i]       = 1'b1;
    fu_preg[i*7 +: 7]  = p;
    fu_val[i*32 +: 32] = v;
    fu_tag[i*5 +: 5]   = t;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    clear_fu();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // hand-computed per-cycle expectations for the saturation run
  logic [1:0] sat_valid [8] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
  logic       sat_rdy   [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [1:0] sat_l0    [8] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
  logic [1:0] sat_l1    [8] = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0};

  initial begin
    int seq [4];
    int exp_seq [4];
    int f;
    logic [3:0] acc;

    reset = 1'b1;
    flush = 1'b0;
    clear_fu();
    #2;
    chk("rst_ready", 64'(cdb_ready), 64'd0);
    chk("rst_valid", 64'(bcast_valid), 64'd0);
    do_reset();

    // single result from FU1
    set_fu(1, 7'h12, 32'hDEADBEEF, 5'd3);
    @(negedge clk);
    chk("t1_ready", 64'(cdb_ready), 64'd1);
    chk("t1_idle", 64'(bcast_valid), 64'd0);
    tick();
    clear_fu();
    @(negedge clk);
    chk("t1_valid", 64'(bcast_valid), 64'd1);
    chk("t1_preg", 64'(bcast_preg[6:0]), 64'h12);
    chk("t1_val", 64'(bcast_val[31:0]), 64'hDEADBEEF);
    chk("t1_tag", 64'(bcast_tag[4:0]), 64'd3);
    chk("t1_fu", 64'(bcast_fu[1:0]), 64'd1);
    tick();
    @(negedge clk);
    chk("t1_drain", 64'(bcast_valid), 64'd0);

    // three-way arbitration from rr_ptr=0
    do_reset();
    set_fu(0, 7'h01, 32'h100, 5'd1);
    set_fu(1, 7'h02, 32'h200, 5'd2);
    set_fu(2, 7'h03, 32'h300, 5'd3);
    tick();
    clear_fu();
    @(negedge clk);
    chk("t2_c1_valid", 64'(bcast_valid), 64'd3);
    chk("t2_c1_l0fu", 64'(bcast_fu[1:0]), 64'd0);
    chk("t2_c1_l1fu", 64'(bcast_fu[3:2]), 64'd1);
    chk("t2_c1_l1val", 64'(bcast_val[63:32]), 64'h200);
    tick();
    @(negedge clk);
    chk("t2_c2_valid", 64'(bcast_valid), 64'd1);
    chk("t2_c2_l0fu", 64'(bcast_fu[1:0]), 64'd2);
    chk("t2_c2_l0preg", 64'(bcast_preg[6:0]), 64'h03);
    tick();
    // rr_ptr should now be 3: FU3 wins lane0 over FU0
    set_fu(0, 7'h04, 32'h400, 5'd4);
    set_fu(3, 7'h05, 32'h500, 5'd5);
    tick();
    clear_fu();
    @(negedge clk);
    chk("t2_rr_valid", 64'(bcast_valid), 64'd3);
    chk("t2_rr_l0fu", 64'(bcast_fu[1:0]), 64'd3);
    chk("t2_rr_l1fu", 64'(bcast_fu[3:2]), 64'd0);
    chk("t2_rr_l0val", 64'(bcast_val[31:0]), 64'h500);
    tick();

    // saturation: all FUs push 3 results, holding each until accepted
    do_reset();
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0;
      exp_seq[i] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      clear_fu();
      for (int i = 0; i < 4; i++)
        if (seq[i] < 3) set_fu(i, 7'(i*8 + seq[i]), 32'(i*16 + seq[i]), 5'(seq[i]));
      @(negedge clk);
      chk($sformatf("sat%0d_ready", c), 64'(cdb_ready), 64'(sat_rdy[c]));
      chk($sformatf("sat%0d_valid", c), 64'(bcast_valid), 64'(sat_valid[c]));
      if (sat_valid[c] != 2'b00) begin
        chk($sformatf("sat%0d_l0fu", c), 64'(bcast_fu[1:0]), 64'(sat_l0[c]));
        chk($sformatf("sat%0d_l1fu", c), 64'(bcast_fu[3:2]), 64'(sat_l1[c]));
      end
      for (int k = 0; k < 2; k++) begin
        if (bcast_valid[k]) begin
          f = int'(bcast_fu[k*2 +: 2]);
          chk($sformatf("sat%0d_l%0d_val", c, k), 64'(bcast_val[k*32 +: 32]),
              64'(f*16 + exp_seq[f]));
          chk($sformatf("sat%0d_l%0d_tag", c, k), 64'(bcast_tag[k*5 +: 5]), 64'(exp_seq[f]));
          exp_seq[f]++;
        end
      end
      acc = fu_valid & {4{cdb_ready}};
      tick();
      for (int i = 0; i < 4; i++) if (acc[i]) seq[i]++;
    end
    clear_fu();
    for (int i = 0; i < 4; i++) chk($sformatf("sat_total_fu%0d", i), 64'(exp_seq[i]), 64'd3);

    // flush with three entries buffered and FU2 pushing in the flush cycle
    do_reset();
    set_fu(0, 7'h10, 32'hA0, 5'd0);
    set_fu(1, 7'h11, 32'hA1, 5'd1);
    set_fu(2, 7'h12, 32'hA2, 5'd2);
    tick();
    clear_fu();
    flush = 1'b1;
    set_fu(2, 7'h13, 32'hA3, 5'd3);
    @(negedge clk);
    chk("fl_valid", 64'(bcast_valid), 64'd0);
    chk("fl_ready", 64'(cdb_ready), 64'd0);
    tick();
    flush = 1'b0;
    clear_fu();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("fl_post%0d_valid", c), 64'(bcast_valid), 64'd0);
      chk($sformatf("fl_post%0d_ready", c), 64'(cdb_ready), 64'd1);
      tick();
    end
    set_fu(3, 7'h20, 32'hB3, 5'd7);
    set_fu(0, 7'h21, 32'hB0, 5'd6);
    tick();
    clear_fu();
    @(negedge clk);
    chk("fl_rr_l0fu", 64'(bcast_fu[1:0]), 64'd0);
    chk("fl_rr_l1fu", 64'(bcast_fu[3:2]), 64'd3);
    tick();

    // asynchronous reset while both lanes are active
    do_reset();
    set_fu(0, 7'h30, 32'hC0, 5'd0);
    set_fu(1, 7'h31, 32'hC1, 5'd1);
    tick();
    clear_fu();
    @(negedge clk);
    chk("ar_before", 64'(bcast_valid), 64'd3);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_valid", 64'(bcast_valid), 64'd0);
    chk("ar_ready", 64'(cdb_ready), 64'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("ar_post%0d_valid", c), 64'(bcast_valid), 64'd0);
      chk($sformatf("ar_post%0d_ready", c), 64'(cdb_ready), 64'd1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Slave end of the common data bus (CDB). It accepts completed results (valid, physical reg addr, value, ROB tag) from every functional unit (FU), one lane per FU.
- Results are buffered in per-FU FIFOs and drive a single shared ready back to all FUs.
- Each cycle, up to NUM_BCAST results are round-robin arbitrated onto broadcast lanes.
- Broadcast lanes feed the reservation stations, ROB and physical register file.

Parameters:
NUM_FU, 4, number of FU producer lanes (matches `NUM_OF_FU)
PREG_W, 7, physical register address width (`PHYSICAL_REG_NUM_WIDTH)
VAL_W, 32, result value width (`REG_VAL_WIDTH)
TAG_W, 5, ROB tag width (`ROB_SIZE_WIDTH)
FIFO_DEPTH, 2, entries per FU FIFO (power of 2, >=2)
NUM_BCAST, 2, broadcast lanes per cycle (1..NUM_FU)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline flush (mispredict/exception)
fu_valid  in  NUM_FU  per-FU result valid
fu_preg  in  NUM_FU*PREG_W  per-FU destination physical reg, FU i at bits [i*PREG_W +: PREG_W]
fu_val  in  NUM_FU*VAL_W  per-FU result value, same packing
fu_tag  in  NUM_FU*TAG_W  per-FU ROB tag, same packing
cdb_ready  out  1  shared ready to all FUs
bcast_valid  out  NUM_BCAST  lane k carries a result
bcast_preg  out  NUM_BCAST*PREG_W  lane k destination physical reg
bcast_val  out  NUM_BCAST*VAL_W  lane k value
bcast_tag  out  NUM_BCAST*TAG_W  lane k ROB tag
bcast_fu  out  NUM_BCAST*$clog2(NUM_FU)  lane k source FU index (debug/verification)

Behaviour:
- Reset (async, active-high):
  - All FIFO counts and pointers 0; rr_ptr 0.
  - bcast_valid all 0; other bcast fields don't-care.
  - cdb_ready 0 while reset is high.
- cdb_ready:
  - Combinational from registered state.
  - 1 iff reset is low, flush is low, and every FU FIFO count < FIFO_DEPTH at the start of the cycle.
  - Conservative: a full FIFO holds ready low even when it pops that cycle.
- Push:
  - fu_valid[i] && cdb_ready at a rising edge writes {preg, val, tag} into FIFO i.
  - fu_valid[i] with cdb_ready=0 is ignored; the FU must hold its result until accepted.
  - At most one push per FU per cycle.
- Latency:
  - An entry pushed at edge N is eligible for broadcast in cycle N+1.
  - bcast_* are combinational from the FIFO heads and the grant.
  - Pop happens at the end of the broadcast cycle. No same-cycle bypass.
- Arbitration:
  - Scan FUs rr_ptr, rr_ptr+1, … (mod NUM_FU).
  - Grant the first NUM_BCAST non-empty FIFOs; lane k gets the k-th grant in scan order.
  - Unused lanes have bcast_valid=0. Each granted FIFO pops exactly one entry at the edge.
  - rr_ptr moves to (last granted FU + 1) mod NUM_FU; unchanged if nothing is granted.
- Ordering: results from the same FU broadcast in push order. No ordering guarantee across FUs.
- Simultaneous push+pop on one FIFO: count unchanged, both operations take effect.
- Wrap-around: FIFO read/write pointers wrap modulo FIFO_DEPTH; count tracks 0..FIFO_DEPTH.
- Flush:
  - In the flush cycle, bcast_valid is forced to 0 and cdb_ready is 0.
  - At the edge, all FIFOs are emptied and rr_ptr is set to 0; pushes in that cycle are dropped.
  - Flush has priority over push and pop.
- No back-pressure from broadcast consumers: granted lanes are always consumed.

Test Plan:
- Single result: after reset, FU1 presents preg=0x12, val=0xDEADBEEF, tag=3 for one cycle with ready=1 -> next cycle bcast_valid=2'b01, lane0 carries 0x12/0xDEADBEEF/3 with bcast_fu=1; the following cycle bcast_valid=0.
- Arbitration (NUM_BCAST=2): FU0, FU1, FU2 push in the same cycle -> cycle+1: lane0=FU0, lane1=FU1; cycle+2: lane0=FU2; rr_ptr ends at 3.
- Fairness: FU0 and FU3 each push every cycle with NUM_BCAST=1 -> broadcasts alternate FU0, FU3, …; neither FU waits more than 1 extra cycle.
- Back-pressure: with FIFO_DEPTH=2, NUM_BCAST=1, all 4 FUs push on 2 consecutive cycles -> cdb_ready falls once a FIFO reaches 2 entries. Held FU inputs are accepted only after ready rises. All 8 results appear exactly once, in per-FU order.
- Flush: fill FIFOs with 3 entries, assert flush for 1 cycle with FU2 valid -> in the flush cycle bcast_valid=0 and ready=0; afterwards nothing is broadcast and ready=1.
- Async reset: assert reset mid-cycle while lanes are active -> bcast_valid drops to 0 immediately, without waiting for a clock edge. After release, ready=1 and no stale entry is ever broadcast.
